// File: rtl/fdiv_pkg.sv
// Shared encodings and default timing constants for the divider chain and its
// measurement helpers.
package fdiv_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned CLK_HZ       = 100_000_000;
    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned TIMEOUT_DEF  = 2 * CLK_HZ;
    localparam int unsigned LOCK_CNT_DEF = 3;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop; flags single-cycle rise/fall of an
// asynchronous input in the clk_in domain.
module sync_edge_det (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // NOTE: non-blocking assignments make the three flops shift as a chain;
    // blocking ones would collapse them into a single stage.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in cycles,
// with a lock indicator and a sticky no-activity timeout.
module clk_period_meter
    import fdiv_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned MCNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [MCNT_W-1:0] LOCK_MAX = MCNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);

    logic rise, fall;

    sync_edge_det u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   hi_cap_q;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   high_time_q;
    logic               meas_valid_q;
    logic               locked_q;
    logic               timeout_q;
    logic [MCNT_W-1:0]  mcnt_q;
    logic               prev_valid_q;
    logic [MCNT_W-1:0]  mcnt_d;

    // period_q doubles as the previous period, so matching compares the running
    // count against it before it is overwritten.
    // NOTE: every always_comb output gets a value on every path, otherwise a
    // latch is inferred.
    always_comb begin
        mcnt_d = '0;
        if (prev_valid_q && (cnt_q == period_q)) begin
            mcnt_d = (mcnt_q == LOCK_MAX) ? mcnt_q : mcnt_q + MCNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hi_cap_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            mcnt_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rise) begin
                        period_q     <= cnt_q;
                        high_time_q  <= hi_cap_q;
                        meas_valid_q <= 1'b1;
                        timeout_q    <= 1'b0;
                        cnt_q        <= CNT_W'(1);
                        mcnt_q       <= mcnt_d;
                        locked_q     <= (mcnt_d == LOCK_MAX);
                        prev_valid_q <= 1'b1;
                    end else if (cnt_q == TO_VAL) begin
                        // Signal stalled: keep the last results, drop lock history.
                        timeout_q    <= 1'b1;
                        locked_q     <= 1'b0;
                        mcnt_q       <= '0;
                        prev_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (fall) begin
                            hi_cap_q <= cnt_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: each table row drives one waveform period
// starting with a rise and states what that rise must report.
module tb_clk_period_meter;

    localparam int CNT_W = 32;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (100),
        .LOCK_CNT (3)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    // per/hi: waveform period and high time starting with a rise at k=0.
    // rst_at: cycle within the row at which reset is pulsed (-1 = none).
    // exp_meas: whether the opening rise yields a measurement (at k=3),
    // with expected e_per/e_hi/e_lock; e_to_k: cycle where timeout rises.
    typedef struct {
        int per;
        int hi;
        int rst_at;
        int exp_meas;
        int e_per;
        int e_hi;
        int e_lock;
        int e_to_k;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    int n_checks = 0;
    int n_fail   = 0;
    logic to_prev = 1'b0;
    int last_per = 0;
    int last_hi  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".period"},     period,     0);
        check({tag, ".high_time"},  high_time,  0);
        check({tag, ".meas_valid"}, meas_valid, 0);
        check({tag, ".locked"},     locked,     0);
        check({tag, ".timeout"},    timeout,    0);
    endtask

    task automatic apply(input int idx, input vec_t e);
        int strobes = 0;
        int to_k    = -1;
        for (int k = 0; k < e.per; k++) begin
            @(posedge clk_in);
            #1;
            sig_in = (k < e.hi);
            if (e.rst_at >= 0 && k == e.rst_at + 1) rst_n = 1'b1;
            @(negedge clk_in);
            if (meas_valid) begin
                strobes++;
                check($sformatf("v%0d.strobe_cycle", idx), k, 3);
                check($sformatf("v%0d.period", idx), period, e.e_per);
                check($sformatf("v%0d.high_time", idx), high_time, e.e_hi);
                check($sformatf("v%0d.locked", idx), locked, e.e_lock);
                check($sformatf("v%0d.timeout_clr", idx), timeout, 0);
                last_per = e.e_per;
                last_hi  = e.e_hi;
            end
            if (timeout && !to_prev) begin
                if (to_k < 0) to_k = k;
                check($sformatf("v%0d.to_locked", idx), locked, 0);
                check($sformatf("v%0d.to_period_kept", idx), period, last_per);
                check($sformatf("v%0d.to_high_kept", idx), high_time, last_hi);
            end
            to_prev = timeout;
            if (k == e.rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_zero_outputs($sformatf("v%0d.midrst", idx));
                to_prev  = 1'b0;
                last_per = 0;
                last_hi  = 0;
            end
        end
        check($sformatf("v%0d.strobes", idx), strobes, e.exp_meas);
        check($sformatf("v%0d.timeout_cycle", idx), to_k, e.e_to_k);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            per  hi rst meas  per  hi lock to_k
        tbl[0]  = '{ 20,  8, -1, 0,   0,  0, 0,  -1};
        tbl[1]  = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[2]  = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[3]  = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[4]  = '{ 20,  8, -1, 1,  20,  8, 1,  -1};
        tbl[5]  = '{ 30, 15, -1, 1,  20,  8, 1,  -1};
        tbl[6]  = '{ 30, 15, -1, 1,  30, 15, 0,  -1};
        tbl[7]  = '{ 30, 15, -1, 1,  30, 15, 0,  -1};
        tbl[8]  = '{ 30, 15, -1, 1,  30, 15, 0,  -1};
        tbl[9]  = '{ 30, 15, -1, 1,  30, 15, 1,  -1};
        tbl[10] = '{155,  5, -1, 1,  30, 15, 1, 103};
        tbl[11] = '{ 20,  8, -1, 0,   0,  0, 0,  -1};
        tbl[12] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[13] = '{100, 50, -1, 1,  20,  8, 0,  -1};
        tbl[14] = '{ 20,  8, -1, 1, 100, 50, 0,  -1};
        tbl[15] = '{  4,  2, -1, 1,  20,  8, 0,  -1};
        tbl[16] = '{  4,  2, -1, 1,   4,  2, 0,  -1};
        tbl[17] = '{  4,  2, -1, 1,   4,  2, 0,  -1};
        tbl[18] = '{  4,  2, -1, 1,   4,  2, 0,  -1};
        tbl[19] = '{  4,  2, -1, 1,   4,  2, 1,  -1};
        tbl[20] = '{ 20,  8, -1, 1,   4,  2, 1,  -1};
        tbl[21] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[22] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[23] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[24] = '{ 20,  8, 12, 1,  20,  8, 1,  -1};
        tbl[25] = '{ 20,  8, -1, 0,   0,  0, 0,  -1};
        tbl[26] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};
        tbl[27] = '{ 20,  8, -1, 1,  20,  8, 0,  -1};

        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_zero_outputs("reset");
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("idle.meas_valid", meas_valid, 0);
        check("idle.timeout", timeout, 0);

        for (int i = 0; i < NV; i++) begin
            apply(i, tbl[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
